// File: rtl/memsync_pkg.sv
// memsync_pkg: FSM states and transfer direction codes for sync_engine.
package memsync_pkg;
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
`ifdef SYNC_ENGINE_WRITEBACK_EN
    WB,
`endif
    FILL,
    SYNC,
    RELEASE
  } state_t;
  localparam logic DIR_FILL = 1'b0;
  localparam logic DIR_WB = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among requests, starting one past the last served index.
module rr_arbiter #(
  parameter int W = 4,
  localparam int N = 2 ** W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);
  // Scan from farthest to nearest so the closest requester past ptr wins.
  always_comb begin
    idx = ptr;
    valid = 1'b0;
    for (int i = N; i >= 1; i--)
      if (req[ptr + W'(i)]) begin
        idx = ptr + W'(i);
        valid = 1'b1;
      end
  end
  assign gnt = valid ? N'(1) << idx : '0;
endmodule

// File: rtl/sync_engine.sv
// sync_engine: serialises per-bank row-cache allocations into beat copies, then pulses sync.
// SYNC_ENGINE_WRITEBACK_EN adds the dirty-row writeback pass before the fill.
module sync_engine
  import memsync_pkg::*;
#(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int CHWIDTH = 6,
  parameter int ADDRWIDTH = 17,
  parameter int BEATS = 8,
  localparam int BKW = BGWIDTH + BAWIDTH,
  localparam int NBANKS = 2 ** BKW,
  localparam int BTW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NBANKS-1:0]             stall,
  input  logic [NBANKS-1:0]             dirty,
  input  logic [NBANKS*ADDRWIDTH-1:0]   RowId,
  input  logic [NBANKS*CHWIDTH-1:0]     cRowId,
  output logic [NBANKS-1:0]             sync,
  output logic                          xfer_valid,
  input  logic                          xfer_ready,
  output logic                          xfer_dir,
  output logic [BKW-1:0]                xfer_bank,
  output logic [ADDRWIDTH-1:0]          xfer_row,
  output logic [CHWIDTH-1:0]            xfer_crow,
  output logic [BTW-1:0]                xfer_beat,
  output logic                          busy
);
  state_t state, next;
  logic [BKW-1:0] ptr, idx;
  logic [NBANKS-1:0] gnt, bank_oh;
  logic valid, acc, last;
  rr_arbiter #(.W(BKW)) u_arb (.req(stall), .ptr(ptr), .gnt(gnt), .idx(idx), .valid(valid));
  assign acc = xfer_valid && xfer_ready;
  assign last = xfer_beat == BTW'(BEATS - 1);
`ifdef SYNC_ENGINE_WRITEBACK_EN
  assign xfer_valid = state == FILL || state == WB;
  assign xfer_dir = state == WB ? DIR_WB : DIR_FILL;
`else
  logic unused_dirty;
  assign unused_dirty = ^dirty;
  assign xfer_valid = state == FILL;
  assign xfer_dir = DIR_FILL;
`endif
  assign sync = state == SYNC ? bank_oh : '0;
  assign busy = state != IDLE;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = |stall ? GRANT : IDLE;
      GRANT: begin
        next = valid ? FILL : IDLE;
`ifdef SYNC_ENGINE_WRITEBACK_EN
        if (valid && dirty[idx]) next = WB;
      end
      WB: begin
        if (acc && last) next = FILL;
`endif
      end
      FILL: next = acc && last ? SYNC : FILL;
      SYNC: next = RELEASE;
      // Hold until the served request is withdrawn so it is never granted twice.
      RELEASE: next = |(stall & bank_oh) ? RELEASE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '1;
      bank_oh <= '0;
      xfer_bank <= '0;
      xfer_row <= '0;
      xfer_crow <= '0;
      xfer_beat <= '0;
    end else begin
      state <= next;
      if (state == GRANT && valid) begin
        ptr <= idx;
        bank_oh <= gnt;
        xfer_bank <= idx;
        xfer_row <= RowId[idx*ADDRWIDTH +: ADDRWIDTH];
        xfer_crow <= cRowId[idx*CHWIDTH +: CHWIDTH];
      end
      if (acc) xfer_beat <= last ? '0 : xfer_beat + 1'b1;
    end
  end
endmodule

// File: doc/sync_engine.md
SYNC_ENGINE -- requirements
Module: sync_engine

Interface
REQ-001 SHALL have parameters: BGWIDTH, default 2, bank-group address bits; BAWIDTH, default 2, bank address bits; CHWIDTH, default 6, cache-row index bits; ADDRWIDTH, default 17, row address bits; BEATS, default 8, data beats per row copy (>=1).
REQ-002 SHALL derive NBANKS = 2**(BGWIDTH+BAWIDTH); flat bank index = bg*2**BAWIDTH + ba.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  NBANKS  per-bank row-cache allocate request (level, held until sync).
REQ-006 dirty  input  NBANKS  per-bank: evicted cache row needs writeback before fill.
REQ-007 RowId  input  NBANKS*ADDRWIDTH  per-bank requested row, bank i at [i*ADDRWIDTH +: ADDRWIDTH].
REQ-008 cRowId  input  NBANKS*CHWIDTH  per-bank allocated cache row, same packing.
REQ-009 sync  output  NBANKS  one-cycle pulse releasing the bank from Allocate.
REQ-010 xfer_valid  output  1  copy beat request; xfer_ready  input  1  backing store accepts beat.
REQ-011 xfer_dir  output  1  0=fill (store->cache), 1=writeback; xfer_bank  output  BGWIDTH+BAWIDTH; xfer_row  output  ADDRWIDTH; xfer_crow  output  CHWIDTH; xfer_beat  output  $clog2(BEATS) or 1 if BEATS=1.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, GRANT, WB, FILL, SYNC, RELEASE.
REQ-014 IDLE: if any stall bit set, -> GRANT next cycle; else stay.
REQ-015 GRANT: round-robin pick among stall bits, starting one past last served bank; latch bank, RowId, cRowId, dirty into registers; -> WB if latched dirty, else FILL.
REQ-016 Requester fields (RowId, cRowId, dirty) SHALL be sampled only in GRANT; later input changes have no effect on the transfer.
REQ-017 WB/FILL: xfer_valid=1, xfer_dir per state, xfer_beat=beat counter; counter increments only on xfer_valid&&xfer_ready.
REQ-018 Beat BEATS-1 accepted: counter wraps to 0; WB -> FILL, FILL -> SYNC.
REQ-019 xfer_ready low SHALL hold all xfer_* outputs stable; no timeout.
REQ-020 SYNC: sync[latched bank]=1 for exactly one cycle, all other sync bits 0; -> RELEASE.
REQ-021 RELEASE: wait until stall[latched bank]==0, then -> IDLE; the bank is never re-granted while its old request is still visible.
REQ-022 Stall of the granted bank dropping before SYNC SHALL NOT abort the transfer; sync still pulses.
REQ-023 Only one transfer in flight; other banks wait; no bank starves (max wait NBANKS-1 transfers).
REQ-024 Minimum latency stall->sync with xfer_ready tied high, clean row: 1+1+BEATS+1 = BEATS+3 cycles.

Reset
REQ-025 reset high at a clock edge: state=IDLE, sync=0, xfer_valid=0, xfer_dir=0, xfer_bank/row/crow/beat=0, busy=0, round-robin pointer=NBANKS-1 (bank 0 served first).
REQ-026 Reset mid-transfer SHALL abandon it with no sync pulse; the still-asserted request is re-served after reset.

Configuration
REQ-027 Macro SYNC_ENGINE_WRITEBACK_EN: defined -> WB state and dirty behaviour as above; undefined -> dirty ignored, GRANT always -> FILL, xfer_dir constant 0, WB state absent.

Structure
REQ-028 Package memsync_pkg SHALL hold the FSM state enum and xfer_dir encodings (DIR_FILL, DIR_WB).
REQ-029 Sub-module rr_arbiter (request vector, pointer, one-hot grant plus index) SHALL implement REQ-015 selection.

Verification
REQ-030 Reset then stall[0]=1, dirty=0, ready=1, BEATS=8: 8 fill beats 0..7 with xfer_row=RowId[0]; sync[0] pulses once, 11 cycles after stall.
REQ-031 stall[5]=1, dirty[5]=1 (macro defined): 8 beats xfer_dir=1 then 8 beats xfer_dir=0, then sync[5]; macro undefined: only 8 fill beats.
REQ-032 stall[3], stall[7], stall[12] asserted same cycle after serving bank 7: service order 12, 3, 7.
REQ-033 xfer_ready toggling 1,0,0,1 per cycle: no beat skipped or repeated, outputs stable while ready=0.
REQ-034 stall[2] held high 4 cycles after sync[2]: no second grant to bank 2 until stall[2]=0; busy high throughout.
REQ-035 reset asserted during beat 4 of FILL: no sync, outputs at reset values, transfer restarts from beat 0 afterwards.
